// File: rtl/pool_engine_mc.sv
// Multi-channel K x K pooling engine: streams window samples from a read memory,
// folds them into one accumulator and writes one pooled result per window.
module pool_engine_mc #(
  parameter int DW     = 8,
  parameter int IMG_W  = 7,
  parameter int IMG_H  = 7,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int CH     = 1,
  parameter int RD_LAT = 1,
  parameter int AW     = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [1:0]    i_mode,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic [2:0]    o_state_dbg
);
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int ACW   = DW + $clog2(K * K + 1);

  localparam logic [AW-1:0] A_ONE    = AW'(1);
  localparam logic [AW-1:0] A_KM1    = AW'(K - 1);
  localparam logic [AW-1:0] A_OWM1   = AW'(OUT_W - 1);
  localparam logic [AW-1:0] A_OHM1   = AW'(OUT_H - 1);
  localparam logic [AW-1:0] A_CHM1   = AW'(CH - 1);
  localparam logic [AW-1:0] A_STR    = AW'(STRIDE);
  localparam logic [AW-1:0] A_IW     = AW'(IMG_W);
  localparam logic [AW-1:0] A_OW     = AW'(OUT_W);
  localparam logic [AW-1:0] A_PLANE  = AW'(IMG_W * IMG_H);
  localparam logic [AW-1:0] A_OPLANE = AW'(OUT_W * OUT_H);
  localparam logic [7:0]    WAIT_LAST = 8'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic [ACW-1:0] C_KK  = ACW'(K * K);
  localparam logic [ACW-1:0] C_SAT = ACW'((1 << DW) - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_ACC  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t         r_state, w_next;
  logic [1:0]     r_mode;
  logic [AW-1:0]  r_kx, r_ky, r_ox, r_oy, r_c;
  logic [7:0]     r_wait;
  logic [ACW-1:0] r_acc;

  logic           w_first, w_last_sample, w_last_win;
  logic [ACW-1:0] w_samp;
  logic [AW-1:0]  w_rd_addr, w_wr_addr;
  logic [DW-1:0]  w_result;

  assign w_first       = (r_kx == '0) && (r_ky == '0);
  assign w_last_sample = (r_kx == A_KM1) && (r_ky == A_KM1);
  assign w_last_win    = (r_ox == A_OWM1) && (r_oy == A_OHM1) && (r_c == A_CHM1);
  assign w_samp        = ACW'(i_rd_data);
  assign w_rd_addr     = r_c * A_PLANE + (r_oy * A_STR + r_ky) * A_IW + r_ox * A_STR + r_kx;
  assign w_wr_addr     = r_c * A_OPLANE + r_oy * A_OW + r_ox;

  always_comb begin
    w_result = '0;
    case (r_mode)
      2'd2:    w_result = DW'(r_acc / C_KK);
      2'd3:    w_result = (r_acc > C_SAT) ? DW'(C_SAT) : DW'(r_acc);
      default: w_result = DW'(r_acc);
    endcase
  end

  // Address/data buses are gated so they read zero whenever their strobe is low.
  assign o_rd_addr   = o_rd_en ? w_rd_addr : '0;
  assign o_wr_addr   = o_wr_en ? w_wr_addr : '0;
  assign o_wr_data   = o_wr_en ? w_result : '0;
  assign o_state_dbg = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_rd_en = 1'b0;
    o_wr_en = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RD;
      S_RD: begin
        o_busy  = 1'b1;
        o_rd_en = 1'b1;
        w_next  = (RD_LAT > 1) ? S_WAIT : S_ACC;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (r_wait == WAIT_LAST) w_next = S_ACC;
      end
      S_ACC: begin
        o_busy = 1'b1;
        w_next = w_last_sample ? S_WR : S_RD;
      end
      S_WR: begin
        o_busy  = 1'b1;
        o_wr_en = 1'b1;
        w_next  = w_last_win ? S_DONE : S_RD;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= '0;
      r_kx   <= '0;
      r_ky   <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_c    <= '0;
      r_wait <= '0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mode <= i_mode;
          r_kx   <= '0;
          r_ky   <= '0;
          r_ox   <= '0;
          r_oy   <= '0;
          r_c    <= '0;
          r_acc  <= '0;
        end
        S_RD:   r_wait <= '0;
        S_WAIT: r_wait <= r_wait + 8'd1;
        S_ACC: begin
          if (w_first) r_acc <= w_samp;
          else begin
            case (r_mode)
              2'd0:    if (w_samp > r_acc) r_acc <= w_samp;
              2'd1:    if (w_samp < r_acc) r_acc <= w_samp;
              default: r_acc <= r_acc + w_samp;
            endcase
          end
          // kx/ky wrap back to zero after the last sample, ready for the next window.
          if (r_kx == A_KM1) begin
            r_kx <= '0;
            r_ky <= (r_ky == A_KM1) ? '0 : r_ky + A_ONE;
          end else begin
            r_kx <= r_kx + A_ONE;
          end
        end
        S_WR: begin
          if (r_ox == A_OWM1) begin
            r_ox <= '0;
            if (r_oy == A_OHM1) begin
              r_oy <= '0;
              r_c  <= (r_c == A_CHM1) ? '0 : r_c + A_ONE;
            end else begin
              r_oy <= r_oy + A_ONE;
            end
          end else begin
            r_ox <= r_ox + A_ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_engine_mc.sv
// Bench for pool_engine_mc: two instances (7x7 K3 S2, CH1/RD_LAT1 and CH2/RD_LAT2)
// driven together and compared against a window-by-window reference model.
module tb_pool_engine_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [1:0] mode;

  logic        busy_a, done_a, rd_en_a, wr_en_a;
  logic [15:0] rd_addr_a, wr_addr_a;
  logic [7:0]  rd_data_a, wr_data_a;
  logic [2:0]  state_a;
  logic        busy_b, done_b, rd_en_b, wr_en_b;
  logic [15:0] rd_addr_b, wr_addr_b;
  logic [7:0]  rd_data_b, wr_data_b, pipe_b;
  logic [2:0]  state_b;

  pool_engine_mc #(.CH(1), .RD_LAT(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .o_busy(busy_a), .o_done(done_a), .o_rd_en(rd_en_a), .o_rd_addr(rd_addr_a),
    .i_rd_data(rd_data_a), .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a),
    .o_wr_data(wr_data_a), .o_state_dbg(state_a));

  pool_engine_mc #(.CH(2), .RD_LAT(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .o_busy(busy_b), .o_done(done_b), .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b),
    .i_rd_data(rd_data_b), .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b),
    .o_wr_data(wr_data_b), .o_state_dbg(state_b));

  logic [7:0] img_a [0:48];
  logic [7:0] img_b [0:97];

  // Read memories: data is only meaningful RD_LAT cycles after a strobe, garbage otherwise.
  always @(posedge clk) begin
    rd_data_a <= (rd_en_a && rd_addr_a < 16'd49) ? img_a[rd_addr_a[5:0]] : 8'($urandom);
    pipe_b    <= (rd_en_b && rd_addr_b < 16'd98) ? img_b[rd_addr_b[6:0]] : 8'($urandom);
    rd_data_b <= pipe_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] log_addr_a [0:2047];
  logic [7:0]  log_data_a [0:2047];
  int          log_cyc_a  [0:2047];
  logic [15:0] log_addr_b [0:2047];
  logic [7:0]  log_data_b [0:2047];
  int          log_cyc_b  [0:2047];
  int wn_a = 0, wn_b = 0, rn_a = 0, rn_b = 0;
  int dn_a = 0, dn_b = 0, dcyc_a = 0, dcyc_b = 0, ovl = 0;

  always @(negedge clk) begin
    if (wr_en_a && wn_a < 2048) begin
      log_addr_a[wn_a] <= wr_addr_a;
      log_data_a[wn_a] <= wr_data_a;
      log_cyc_a[wn_a]  <= cyc;
      wn_a <= wn_a + 1;
    end
    if (wr_en_b && wn_b < 2048) begin
      log_addr_b[wn_b] <= wr_addr_b;
      log_data_b[wn_b] <= wr_data_b;
      log_cyc_b[wn_b]  <= cyc;
      wn_b <= wn_b + 1;
    end
    if (rd_en_a) rn_a <= rn_a + 1;
    if (rd_en_b) rn_b <= rn_b + 1;
    if (done_a) begin dn_a <= dn_a + 1; dcyc_a <= cyc; end
    if (done_b) begin dn_b <= dn_b + 1; dcyc_b <= cyc; end
    if ((rd_en_a && wr_en_a) || (rd_en_b && wr_en_b)) ovl <= ovl + 1;
  end

  int n_vec = 0, n_fail = 0;
  logic [23:0] exp_q_a[$];
  logic [23:0] exp_q_b[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pool one window straight from the image, 7x7 planes, K=3, stride 2.
  function automatic int model(input int sel, input int md, input int c, input int oy, input int ox);
    int v, idx;
    int mx = 0, mn = 255, sum = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        idx = c * 49 + (oy * 2 + ky) * 7 + ox * 2 + kx;
        v = (sel == 0) ? int'(img_a[idx]) : int'(img_b[idx]);
        if (v > mx) mx = v;
        if (v < mn) mn = v;
        sum += v;
      end
    case (md)
      0: return mx;
      1: return mn;
      2: return sum / 9;
      default: return (sum > 255) ? 255 : sum;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy_a"}, int'(busy_a), 0);
    check({tag, "_done_a"}, int'(done_a), 0);
    check({tag, "_rden_a"}, int'(rd_en_a), 0);
    check({tag, "_wren_a"}, int'(wr_en_a), 0);
    check({tag, "_rdaddr_a"}, int'(rd_addr_a), 0);
    check({tag, "_wraddr_a"}, int'(wr_addr_a), 0);
    check({tag, "_wrdata_a"}, int'(wr_data_a), 0);
    check({tag, "_state_a"}, int'(state_a), 0);
    check({tag, "_busy_b"}, int'(busy_b), 0);
    check({tag, "_done_b"}, int'(done_b), 0);
    check({tag, "_rden_b"}, int'(rd_en_b), 0);
    check({tag, "_wren_b"}, int'(wr_en_b), 0);
    check({tag, "_rdaddr_b"}, int'(rd_addr_b), 0);
    check({tag, "_wraddr_b"}, int'(wr_addr_b), 0);
    check({tag, "_wrdata_b"}, int'(wr_data_b), 0);
    check({tag, "_state_b"}, int'(state_b), 0);
  endtask

  int pass_wa0;

  task automatic run_pass(input string tag, input int md, input bit disturb);
    int wa0, wb0, ra0, rb0, da0, db0, ov0, t0, waited;
    logic [23:0] e;
    exp_q_a.delete();
    exp_q_b.delete();
    for (int c = 0; c < 2; c++)
      for (int oy = 0; oy < 3; oy++)
        for (int ox = 0; ox < 3; ox++) begin
          if (c == 0) exp_q_a.push_back({16'(oy * 3 + ox), 8'(model(0, md, 0, oy, ox))});
          exp_q_b.push_back({16'(c * 9 + oy * 3 + ox), 8'(model(1, md, c, oy, ox))});
        end
    wa0 = wn_a; wb0 = wn_b; ra0 = rn_a; rb0 = rn_b;
    da0 = dn_a; db0 = dn_b; ov0 = ovl;
    pass_wa0 = wa0;
    @(negedge clk);
    start = 1'b1;
    mode = 2'(md);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_a_c1"}, int'(busy_a), 1);
    check({tag, "_busy_b_c1"}, int'(busy_b), 1);
    waited = 0;
    while ((dn_a == da0 || dn_b == db0) && waited < 800) begin
      @(negedge clk);
      waited++;
      if (disturb && waited == 40) begin start = 1'b1; mode = ~2'(md); end
      if (disturb && waited == 41) start = 1'b0;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, "_timeout"}, int'(waited < 800), 1);
    check({tag, "_idle_a"}, int'(busy_a), 0);
    check({tag, "_idle_b"}, int'(busy_b), 0);
    check({tag, "_wcount_a"}, wn_a - wa0, 9);
    check({tag, "_wcount_b"}, wn_b - wb0, 18);
    check({tag, "_rcount_a"}, rn_a - ra0, 81);
    check({tag, "_rcount_b"}, rn_b - rb0, 162);
    check({tag, "_dcount_a"}, dn_a - da0, 1);
    check({tag, "_dcount_b"}, dn_b - db0, 1);
    check({tag, "_overlap"}, ovl - ov0, 0);
    check({tag, "_done_cyc_a"}, dcyc_a - t0, 172);
    check({tag, "_done_cyc_b"}, dcyc_b - t0, 505);
    if (wn_a - wa0 == 9) check({tag, "_lastwr_a"}, log_cyc_a[wa0 + 8] - t0, 171);
    if (wn_b - wb0 == 18) check({tag, "_lastwr_b"}, log_cyc_b[wb0 + 17] - t0, 504);
    for (int i = 0; i < 9 && i < wn_a - wa0; i++) begin
      e = exp_q_a.pop_front();
      check($sformatf("%s_addr_a%0d", tag, i), int'(log_addr_a[wa0 + i]), int'(e[23:8]));
      check($sformatf("%s_data_a%0d", tag, i), int'(log_data_a[wa0 + i]), int'(e[7:0]));
    end
    for (int i = 0; i < 18 && i < wn_b - wb0; i++) begin
      e = exp_q_b.pop_front();
      check($sformatf("%s_addr_b%0d", tag, i), int'(log_addr_b[wb0 + i]), int'(e[23:8]));
      check($sformatf("%s_data_b%0d", tag, i), int'(log_data_b[wb0 + i]), int'(e[7:0]));
    end
    mode = 2'd0;
  endtask

  task automatic load_ramp();
    for (int n = 0; n < 49; n++) img_a[n] = 8'(n);
    for (int n = 0; n < 49; n++) img_b[n] = 8'(n);
    for (int n = 49; n < 98; n++) img_b[n] = 8'd255;
  endtask

  initial begin : main
    int t0, wa0, wb0, da0, db0, ra0, rb0, md;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    load_ramp();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    run_pass("max", 0, 1'b0);
    check("max_first", int'(log_data_a[pass_wa0]), 16);
    check("max_last", int'(log_data_a[pass_wa0 + 8]), 48);
    run_pass("min", 1, 1'b0);
    check("min_first", int'(log_data_a[pass_wa0]), 0);
    run_pass("avg", 2, 1'b0);
    check("avg_first", int'(log_data_a[pass_wa0]), 8);
    run_pass("sum", 3, 1'b0);
    run_pass("disturb", 0, 1'b1);

    // Abort during the first ACC of window 3 in instance A.
    wa0 = wn_a; wb0 = wn_b; da0 = dn_a; db0 = dn_b;
    @(negedge clk);
    start = 1'b1;
    mode = 2'd0;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    @(negedge clk);
    ra0 = rn_a; rb0 = rn_b;
    repeat (300) @(negedge clk);
    check("midrst_wr_a", wn_a - wa0, 3);
    check("midrst_wr_b", wn_b - wb0, 2);
    check("midrst_done_a", dn_a - da0, 0);
    check("midrst_done_b", dn_b - db0, 0);
    check("midrst_rd_a", rn_a - ra0, 0);
    check("midrst_rd_b", rn_b - rb0, 0);
    run_pass("rerun", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 49; n++) img_a[n] = 8'((r >= 4) ? $urandom_range(180, 255) : $urandom_range(0, 255));
      for (int n = 0; n < 98; n++) img_b[n] = 8'((r >= 4) ? $urandom_range(180, 255) : $urandom_range(0, 255));
      md = (r >= 4) ? 3 : int'($urandom_range(0, 3));
      run_pass($sformatf("rnd%0d", r), md, r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
